// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between a truth-table driver and the checker.
// The master drives sample vectors and start; the slave returns handshake and results.
interface truth_table_checker_if;
    logic        start;
    logic        in_valid;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        f;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [7:0]  sample_count;
    logic [15:0] cov_map;
    logic        first_fail_valid;
    logic [3:0]  first_fail_vec;

    modport master (
        output start, in_valid, a, b, c, d, f,
        input  in_ready, busy, done, pass, err_count, sample_count,
               cov_map, first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, in_valid, a, b, c, d, f,
        output in_ready, busy, done, pass, err_count, sample_count,
               cov_map, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/truth_table_checker.sv
// Checks a 4-input function against a truth table, tracking coverage, mismatches and first failure.
// One-cycle result latency; in_ready is high only while running, samples offered otherwise are dropped.
module truth_table_checker #(
    parameter logic [15:0] EXPECTED    = 16'h6996,
    parameter int          MAX_SAMPLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_checker_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [7:0] MAX_CNT = 8'(MAX_SAMPLES);

    logic [1:0]  state;
    logic        pass_q;
    logic [4:0]  err_count;
    logic [7:0]  sample_count;
    logic [15:0] cov_map;
    logic        first_fail_valid;
    logic [3:0]  first_fail_vec;

    logic        accept;
    logic [3:0]  idx;
    logic        mismatch;
    logic [15:0] cov_next;
    logic [7:0]  cnt_next;
    logic [4:0]  err_next;

    always_comb begin
        idx      = {bus.a, bus.b, bus.c, bus.d};
        accept   = bus.in_valid && (state == RUN);
        mismatch = (bus.f != EXPECTED[idx]);
        cov_next = cov_map | (16'd1 << idx);
        cnt_next = sample_count + 8'd1;
        err_next = (mismatch && (err_count != 5'd31)) ? err_count + 5'd1 : err_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pass_q           <= 1'b0;
            err_count        <= '0;
            sample_count     <= '0;
            cov_map          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state            <= RUN;
                        pass_q           <= 1'b0;
                        err_count        <= '0;
                        sample_count     <= '0;
                        cov_map          <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cov_map      <= cov_next;
                        sample_count <= cnt_next;
                        err_count    <= err_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= idx;
                        end
                        // Full coverage takes priority over the sample limit on the same accept.
                        if (cov_next == 16'hFFFF) begin
                            state  <= DONE;
                            pass_q <= (err_next == 5'd0);
                        end else if (cnt_next == MAX_CNT) begin
                            state  <= DONE;
                            pass_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready         = (state == RUN);
    assign bus.busy             = (state == RUN);
    assign bus.done             = (state == DONE);
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_count;
    assign bus.sample_count     = sample_count;
    assign bus.cov_map          = cov_map;
    assign bus.first_fail_valid = first_fail_valid;
    assign bus.first_fail_vec   = first_fail_vec;
endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with the default parity truth table (16'h6996).
module tb_truth_table_checker;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    truth_table_checker_if bus ();

    truth_table_checker #(
        .EXPECTED    (16'h6996),
        .MAX_SAMPLES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 16'h6996 is the odd-parity function of {a,b,c,d}.
    function automatic logic ref_f(input logic [3:0] v);
        return ^v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v, input logic fv);
        bus.in_valid = 1'b1;
        {bus.a, bus.b, bus.c, bus.d} = v;
        bus.f = fv;
        tick();
    endtask

    task automatic pulse_start();
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " in_ready"}, bus.in_ready, 0);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " done"}, bus.done, 0);
        chk({tag, " pass"}, bus.pass, 0);
        chk({tag, " err_count"}, bus.err_count, 0);
        chk({tag, " sample_count"}, bus.sample_count, 0);
        chk({tag, " cov_map"}, bus.cov_map, 0);
        chk({tag, " ff_valid"}, bus.first_fail_valid, 0);
        chk({tag, " ff_vec"}, bus.first_fail_vec, 0);
    endtask

    initial begin
        logic [3:0] dup_seq [20];
        checks = 0;
        errors = 0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        {bus.a, bus.b, bus.c, bus.d, bus.f} = 5'b0;

        // Reset overrides start and in_valid
        rst = 1'b1;
        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        // Sample offered in IDLE is dropped
        send(4'h3, 1'b0);
        bus.in_valid = 1'b0;
        chk_all_zero("idle_drop");

        // Exhaustive correct sweep
        pulse_start();
        chk("sweep busy", bus.busy, 1);
        chk("sweep in_ready", bus.in_ready, 1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("sweep done_before_last", bus.done, 0);
            send(4'(i), ref_f(4'(i)));
        end
        bus.in_valid = 1'b0;
        chk("sweep done", bus.done, 1);
        chk("sweep busy_off", bus.busy, 0);
        chk("sweep pass", bus.pass, 1);
        chk("sweep err", bus.err_count, 0);
        chk("sweep samples", bus.sample_count, 16);
        chk("sweep cov", bus.cov_map, 16'hFFFF);
        chk("sweep ff_valid", bus.first_fail_valid, 0);
        // Results hold in DONE; extra sample dropped
        send(4'h0, 1'b1);
        bus.in_valid = 1'b0;
        chk("hold samples", bus.sample_count, 16);
        chk("hold err", bus.err_count, 0);
        chk("hold done", bus.done, 1);

        // Start from DONE clears results
        pulse_start();
        chk("restart done", bus.done, 0);
        chk("restart busy", bus.busy, 1);
        chk("restart samples", bus.sample_count, 0);
        chk("restart cov", bus.cov_map, 0);
        chk("restart pass", bus.pass, 0);

        // Sweep with duplicates: 0-7, 0-3, 12-15, 8-11
        for (int i = 0; i < 8; i++) dup_seq[i] = 4'(i);
        for (int i = 0; i < 4; i++) dup_seq[8 + i] = 4'(i);
        for (int i = 0; i < 4; i++) dup_seq[12 + i] = 4'(12 + i);
        for (int i = 0; i < 4; i++) dup_seq[16 + i] = 4'(8 + i);
        for (int i = 0; i < 20; i++) begin
            if (i == 19) begin
                chk("dup done_before_last", bus.done, 0);
                chk("dup cov_before_last", bus.cov_map, 16'hF7FF);
            end
            send(dup_seq[i], ref_f(dup_seq[i]));
        end
        bus.in_valid = 1'b0;
        chk("dup done", bus.done, 1);
        chk("dup samples", bus.sample_count, 20);
        chk("dup pass", bus.pass, 1);

        // Fault injection at vectors 5 and 9
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send(4'(i), ref_f(4'(i)) ^ ((i == 5) || (i == 9)));
            if (i == 5) begin
                chk("fault mid ff_valid", bus.first_fail_valid, 1);
                chk("fault mid err", bus.err_count, 1);
            end
        end
        bus.in_valid = 1'b0;
        chk("fault done", bus.done, 1);
        chk("fault err", bus.err_count, 2);
        chk("fault ff_valid", bus.first_fail_valid, 1);
        chk("fault ff_vec", bus.first_fail_vec, 5);
        chk("fault pass", bus.pass, 0);
        chk("fault cov", bus.cov_map, 16'hFFFF);

        // Timeout: vectors 0..14 repeated, 32 samples
        pulse_start();
        for (int k = 0; k < 32; k++) begin
            if (k == 31) chk("timeout done_before_last", bus.done, 0);
            send(4'(k % 15), ref_f(4'(k % 15)));
        end
        bus.in_valid = 1'b0;
        chk("timeout done", bus.done, 1);
        chk("timeout pass", bus.pass, 0);
        chk("timeout cov", bus.cov_map, 16'h7FFF);
        chk("timeout samples", bus.sample_count, 32);
        chk("timeout err", bus.err_count, 0);

        // Error count saturation: 32 wrong samples of vector 0
        pulse_start();
        for (int k = 0; k < 32; k++) send(4'h0, 1'b1);
        bus.in_valid = 1'b0;
        chk("sat err", bus.err_count, 31);
        chk("sat done", bus.done, 1);
        chk("sat cov", bus.cov_map, 16'h0001);
        chk("sat ff_vec", bus.first_fail_vec, 0);
        chk("sat ff_valid", bus.first_fail_valid, 1);

        // Start mid-run is ignored
        pulse_start();
        for (int i = 0; i < 3; i++) send(4'(i), ref_f(4'(i)));
        pulse_start();
        chk("midstart samples", bus.sample_count, 3);
        chk("midstart cov", bus.cov_map, 16'h0007);
        chk("midstart busy", bus.busy, 1);

        // Reset after 8 accepts discards the run
        for (int i = 3; i < 8; i++) send(4'(i), ref_f(4'(i)));
        bus.in_valid = 1'b0;
        chk("pre_rst samples", bus.sample_count, 8);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk_all_zero("midrun_rst");
        tick();
        tick();
        chk("post_rst done", bus.done, 0);
        chk("post_rst busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
